data_mem_initiator: RTL and testbench
=====================================

DATA_MEM_INITIATOR -- requirements
Module: data_mem_initiator

Interface
REQ-001 clk  in  1  sole clock; all state updates on posedge clk.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 req_valid  in  1  CPU issues a load/store request this cycle.
REQ-004 req_ready  out  1  high only in IDLE; request accepted when req_valid & req_ready.
REQ-005 req_op  in  4  mem_op_t: LB, LBU, LH, LHU, LW, SB, SH, SW.
REQ-006 req_addr  in  32  byte address.
REQ-007 req_wdata  in  32  store data; the low byte, low half or full word is used.
REQ-008 resp_valid  out  1  one-cycle pulse that completes each accepted request.
REQ-009 resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-010 resp_err  out  1  misaligned request; valid with resp_valid.
REQ-011 data_address  out  32  word-aligned bus address, req_addr & ~3.
REQ-012 data_read  out  1  bus read strobe.
REQ-013 data_write  out  1  bus write strobe; never high together with data_read.
REQ-014 data_writedata  out  32  bus write word.
REQ-015 data_readdata  in  32  bus read word, combinational while data_read is high.
REQ-016 data_waitrequest  in  1  bus stall; the current strobe is held until this input is low.

Function
REQ-017 Byte order: byte k of a word (k = addr[1:0]) is data[8k+7:8k]; a half at offset h (h = 0 or 2) is data[8h+15:8h].
REQ-018 FSM states: IDLE, READ, RMW_RD, RMW_WR, WRITE, RESP.
REQ-019 IDLE: on accept, latch op, addr and wdata; misaligned -> RESP with err; LB/LBU/LH/LHU/LW -> READ; SW -> WRITE; SB/SH -> RMW_RD.
REQ-020 Misaligned: halfword ops with addr[0]=1, or word ops with addr[1:0]!=0; no bus strobe is issued.
REQ-021 READ and RMW_RD drive data_read=1; when waitrequest=0, capture data_readdata and move to RESP or RMW_WR respectively.
REQ-022 RMW_WR and WRITE drive data_write=1 with the merged word (RMW_WR) or wdata (WRITE); when waitrequest=0, move to RESP.
REQ-023 RMW merge replaces only the addressed byte or half of the captured word and keeps all other bits.
REQ-024 RESP: resp_valid=1 for exactly one cycle, then IDLE.
REQ-025 Load extension: LB and LH sign-extend; LBU and LHU zero-extend.
REQ-026 Latency with no waits: LW/SW have resp_valid 2 cycles after accept; SB/SH 3 cycles; misaligned 1 cycle; each waitrequest cycle adds 1.
REQ-027 Bus strobes and data_address are driven from registered state only, never combinationally from req_*.
REQ-028 req_valid outside IDLE is ignored; a request is never queued or lost once accepted.

Reset
REQ-029 Reset forces IDLE, all strobes 0, resp_valid 0, resp_err 0, resp_rdata 0, data_address 0, data_writedata 0.
REQ-030 Reset asserted mid-transaction aborts it immediately with no response; an RMW abandoned after its read issues no write.

Structure
REQ-031 Package mem_pkg holds mem_op_t, the FSM state enum and the misalignment function.
REQ-032 Sub-module mem_lane (combinational): load extract/extend and store merge, selected by op and addr[1:0].

Verification
REQ-033 Bus word at 0x480 = 0x12345678; LB at 0x483 -> resp_rdata 0x00000012; LH at 0x480 -> 0x00005678.
REQ-034 Word 0x000080F0; LB at 0x480 -> 0xFFFFFFF0; LBU at 0x480 -> 0x000000F0; LH at 0x480 -> 0xFFFF80F0.
REQ-035 Word 0x12345678; SB at 0x481 with wdata 0xAB -> bus write 0x1234AB78; resp_valid 3 cycles after accept.
REQ-036 LW at 0x482 -> resp_err=1 with no strobe; SH at 0x481 -> resp_err=1 with no strobe.
REQ-037 SW 0xDEADBEEF at 0x484 with waitrequest high for 2 cycles -> data_write held stable for 3 cycles; resp_valid 4 cycles after accept.
REQ-038 Reset asserted during RMW_RD -> no data_write, state IDLE, req_ready=1 in the cycle after reset deasserts.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the data-memory initiator: op codes, FSM states, alignment check.
package mem_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LBU = 4'd1,
        OP_LH  = 4'd2,
        OP_LHU = 4'd3,
        OP_LW  = 4'd4,
        OP_SB  = 4'd5,
        OP_SH  = 4'd6,
        OP_SW  = 4'd7
    } mem_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_WRITE,
        ST_RESP
    } state_t;

    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] off);
        case (op)
            OP_LH, OP_LHU, OP_SH: return off[0];
            OP_LW, OP_SW:         return off != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_initiator_if.sv
// CPU request/response channel plus Avalon-style data bus for the initiator.
interface data_mem_initiator_if;
    import mem_pkg::*;

    logic        req_valid;
    logic        req_ready;
    mem_op_t     req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        data_waitrequest;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, data_readdata, data_waitrequest,
        output req_ready, resp_valid, resp_rdata, resp_err,
               data_address, data_read, data_write, data_writedata
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, data_readdata, data_waitrequest,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               data_address, data_read, data_write, data_writedata
    );

endinterface

// File: rtl/mem_lane.sv
// Combinational byte-lane logic: load extract/extend and sub-word store merge.
module mem_lane
    import mem_pkg::*;
(
    input  mem_op_t     i_op,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_load_word,
    input  logic [31:0] i_base_word,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_load_word[{i_off, 3'b000} +: 8];
    assign w_half = i_load_word[{i_off[1], 4'b0000} +: 16];

    always_comb begin
        o_load = '0;
        case (i_op)
            OP_LB:   o_load = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_load = {24'h0, w_byte};
            OP_LH:   o_load = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_load = {16'h0, w_half};
            OP_LW:   o_load = i_load_word;
            default: o_load = '0;
        endcase

        o_merged = i_base_word;
        case (i_op)
            OP_SB:   o_merged[{i_off, 3'b000} +: 8]     = i_wdata[7:0];
            OP_SH:   o_merged[{i_off[1], 4'b0000} +: 16] = i_wdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_initiator.sv
// Single-outstanding load/store initiator; 1 (error), 2 (LW/SW) or 3 (SB/SH) cycles plus waits.
// Accepts only in IDLE; bus strobes held while data_waitrequest is high.
module data_mem_initiator
    import mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    data_mem_initiator_if.slave   bus
);
    state_t      r_state;
    state_t      w_next;
    mem_op_t     r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rword;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        w_accept;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    assign w_accept = bus.req_valid && (r_state == ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (is_misaligned(bus.req_op, bus.req_addr[1:0])) begin
                        w_next = ST_RESP;
                    end else begin
                        case (bus.req_op)
                            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: w_next = ST_READ;
                            OP_SB, OP_SH:                        w_next = ST_RMW_RD;
                            OP_SW:                               w_next = ST_WRITE;
                            // undefined op codes are answered with an error, like misaligned ones
                            default:                             w_next = ST_RESP;
                        endcase
                    end
                end
            end
            ST_READ:   if (!bus.data_waitrequest) w_next = ST_RESP;
            ST_RMW_RD: if (!bus.data_waitrequest) w_next = ST_RMW_WR;
            ST_RMW_WR: if (!bus.data_waitrequest) w_next = ST_RESP;
            ST_WRITE:  if (!bus.data_waitrequest) w_next = ST_RESP;
            ST_RESP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op    <= OP_LB;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rword <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op    <= bus.req_op;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_rdata <= '0;
                r_err   <= (w_next == ST_RESP);
            end
            if (r_state == ST_READ && !bus.data_waitrequest) begin
                r_rdata <= w_load;
            end
            if (r_state == ST_RMW_RD && !bus.data_waitrequest) begin
                r_rword <= bus.data_readdata;
            end
        end
    end

    mem_lane u_lane (
        .i_op        (r_op),
        .i_off       (r_addr[1:0]),
        .i_load_word (bus.data_readdata),
        .i_base_word (r_rword),
        .i_wdata     (r_wdata[15:0]),
        .o_load      (w_load),
        .o_merged    (w_merged)
    );

    // All bus-facing outputs decode from registered state and latched request fields.
    assign bus.req_ready      = (r_state == ST_IDLE);
    assign bus.resp_valid     = (r_state == ST_RESP);
    assign bus.resp_rdata     = r_rdata;
    assign bus.resp_err       = r_err && (r_state == ST_RESP);
    assign bus.data_address   = {r_addr[31:2], 2'b00};
    assign bus.data_read      = (r_state == ST_READ) || (r_state == ST_RMW_RD);
    assign bus.data_write     = (r_state == ST_RMW_WR) || (r_state == ST_WRITE);
    assign bus.data_writedata = (r_state == ST_RMW_WR) ? w_merged :
                                (r_state == ST_WRITE)  ? r_wdata  : 32'h0;

endmodule

// File: tb/tb_data_mem_initiator.sv
// Directed bench for data_mem_initiator with a single-word bus model and cycle-accurate latency checks.
module tb_data_mem_initiator;
    import mem_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] bus_word;
    int          checks;
    int          errors;

    int          lat;
    logic [31:0] got_rdata;
    logic        got_err;
    int          n_rd;
    int          n_wr;
    logic [31:0] wr_word;
    logic        wr_stable;
    logic        both_seen;
    logic [31:0] seen_addr;

    data_mem_initiator_if bus_if ();

    assign bus_if.data_readdata = bus_word;

    data_mem_initiator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request and watches the bus until the response; waits = waitrequest cycles per strobe phase.
    task automatic run_req(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wd,
                           input int waits, input bit hold);
        lat = -1; got_rdata = 'x; got_err = 'x;
        n_rd = 0; n_wr = 0; wr_word = '0; wr_stable = 1'b1; both_seen = 1'b0; seen_addr = '0;
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.req_op    = op;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = wd;
        @(posedge clk);
        #1 if (!hold) bus_if.req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bus_if.data_waitrequest = (c <= waits);
            if (bus_if.data_read && bus_if.data_write) both_seen = 1'b1;
            if (bus_if.data_read) begin
                n_rd++;
                seen_addr = bus_if.data_address;
            end
            if (bus_if.data_write) begin
                n_wr++;
                if (n_wr > 1 && bus_if.data_writedata !== wr_word) wr_stable = 1'b0;
                wr_word   = bus_if.data_writedata;
                seen_addr = bus_if.data_address;
            end
            if (bus_if.resp_valid) begin
                lat       = c;
                got_rdata = bus_if.resp_rdata;
                got_err   = bus_if.resp_err;
                break;
            end
        end
        bus_if.req_valid        = 1'b0;
        bus_if.data_waitrequest = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus_word = 32'h12345678;
        bus_if.req_valid        = 1'b0;
        bus_if.req_op           = OP_LB;
        bus_if.req_addr         = '0;
        bus_if.req_wdata        = '0;
        bus_if.data_waitrequest = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_ready",     32'(bus_if.req_ready),  32'h1);
        check("rst_resp_vld",  32'(bus_if.resp_valid), 32'h0);
        check("rst_resp_err",  32'(bus_if.resp_err),   32'h0);
        check("rst_rdata",     bus_if.resp_rdata,      32'h0);
        check("rst_read",      32'(bus_if.data_read),  32'h0);
        check("rst_write",     32'(bus_if.data_write), 32'h0);
        check("rst_addr",      bus_if.data_address,    32'h0);
        check("rst_wdata",     bus_if.data_writedata,  32'h0);
        reset = 1'b0;

        // Loads from 0x12345678
        run_req(OP_LB, 32'h483, 32'h0, 0, 1'b0);
        check("lb483_rdata", got_rdata, 32'h00000012);
        check("lb483_lat",   32'(lat),  32'd2);
        check("lb483_err",   32'(got_err), 32'h0);
        check("lb483_nrd",   32'(n_rd), 32'd1);
        check("lb483_addr",  seen_addr, 32'h480);

        run_req(OP_LH, 32'h480, 32'h0, 0, 1'b0);
        check("lh480_rdata", got_rdata, 32'h00005678);

        run_req(OP_LW, 32'h480, 32'h0, 0, 1'b0);
        check("lw480_rdata", got_rdata, 32'h12345678);
        check("lw480_lat",   32'(lat),  32'd2);

        run_req(OP_LB, 32'h482, 32'h0, 1, 1'b0);
        check("lb482w_rdata", got_rdata, 32'h00000034);
        check("lb482w_lat",   32'(lat),  32'd3);

        // Sign/zero extension on 0x000080F0
        bus_word = 32'h000080F0;
        run_req(OP_LB, 32'h480, 32'h0, 0, 1'b0);
        check("lb_sext",  got_rdata, 32'hFFFFFFF0);
        run_req(OP_LBU, 32'h480, 32'h0, 0, 1'b0);
        check("lbu_zext", got_rdata, 32'h000000F0);
        run_req(OP_LH, 32'h480, 32'h0, 0, 1'b0);
        check("lh_sext",  got_rdata, 32'hFFFF80F0);
        run_req(OP_LHU, 32'h480, 32'h0, 0, 1'b0);
        check("lhu_zext", got_rdata, 32'h000080F0);

        // Read-modify-write stores into 0x12345678
        bus_word = 32'h12345678;
        run_req(OP_SB, 32'h481, 32'h000000AB, 0, 1'b0);
        check("sb481_word",  wr_word,   32'h1234AB78);
        check("sb481_lat",   32'(lat),  32'd3);
        check("sb481_nrd",   32'(n_rd), 32'd1);
        check("sb481_nwr",   32'(n_wr), 32'd1);
        check("sb481_rdata", got_rdata, 32'h0);
        check("sb481_both",  32'(both_seen), 32'h0);

        run_req(OP_SH, 32'h482, 32'h1111CAFE, 0, 1'b0);
        check("sh482_word", wr_word,  32'hCAFE5678);
        check("sh482_lat",  32'(lat), 32'd3);

        // Misaligned requests: error, no strobe
        run_req(OP_LW, 32'h482, 32'h0, 0, 1'b0);
        check("lw482_err",   32'(got_err), 32'h1);
        check("lw482_lat",   32'(lat),     32'd1);
        check("lw482_strb",  32'(n_rd + n_wr), 32'd0);
        check("lw482_rdata", got_rdata,    32'h0);
        run_req(OP_SH, 32'h481, 32'h0, 0, 1'b0);
        check("sh481_err",  32'(got_err), 32'h1);
        check("sh481_strb", 32'(n_rd + n_wr), 32'd0);

        // Word store with two wait cycles
        run_req(OP_SW, 32'h484, 32'hDEADBEEF, 2, 1'b0);
        check("sw_word",   wr_word,        32'hDEADBEEF);
        check("sw_nwr",    32'(n_wr),      32'd3);
        check("sw_stable", 32'(wr_stable), 32'h1);
        check("sw_lat",    32'(lat),       32'd4);
        check("sw_addr",   seen_addr,      32'h484);
        check("sw_nrd",    32'(n_rd),      32'd0);

        // req_valid held while busy must not spawn a second transaction
        run_req(OP_LW, 32'h480, 32'h0, 1, 1'b1);
        check("hold_rdata", got_rdata, 32'h12345678);
        begin
            int extra;
            extra = 0;
            repeat (4) begin
                @(negedge clk);
                if (bus_if.resp_valid || bus_if.data_read || bus_if.data_write) extra++;
            end
            check("hold_no_extra", 32'(extra), 32'd0);
        end

        // Reset during RMW read phase abandons the store
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.req_op    = OP_SB;
        bus_if.req_addr  = 32'h480;
        bus_if.req_wdata = 32'h55;
        bus_if.data_waitrequest = 1'b1;
        @(posedge clk);
        #1 bus_if.req_valid = 1'b0;
        @(negedge clk);
        check("rmw_rd_strobe", 32'(bus_if.data_read), 32'h1);
        reset = 1'b1;
        #1;
        check("rmw_rst_read",  32'(bus_if.data_read),  32'h0);
        check("rmw_rst_write", 32'(bus_if.data_write), 32'h0);
        bus_if.data_waitrequest = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rmw_rst_ready", 32'(bus_if.req_ready), 32'h1);
        begin
            int stray;
            stray = 0;
            repeat (4) begin
                @(negedge clk);
                if (bus_if.data_write || bus_if.resp_valid) stray++;
            end
            check("rmw_rst_nowrite", 32'(stray), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
